// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// opcode values, mux select codes and the control-word layout.
// Optional feature macro: MIPS_MC_ADDI_EN adds the ADDIEX/ADDIWB states.
package mips_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_RTEXEC = 4'd7,
    S_RTWB   = 4'd8,
    S_BEQ    = 4'd9,
`ifdef MIPS_MC_ADDI_EN
    S_JUMP   = 4'd10,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
`else
    S_JUMP   = 4'd10
`endif
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Last state of an instruction; leaving it for FETCH retires the instruction.
  function automatic logic is_terminal(input state_e s);
    logic t;
    t = 1'b0;
    case (s)
      S_MEMWB, S_MEMWR, S_RTWB, S_BEQ, S_JUMP: t = 1'b1;
`ifdef MIPS_MC_ADDI_EN
      S_ADDIWB: t = 1'b1;
`endif
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/mips_mc_decode.sv
// Combinational state-to-control-word decoder (Moore outputs).
// Optional feature macro: MIPS_MC_ADDI_EN decodes the addi states.
module mips_mc_decode
  import mips_pkg::*;
(
  input  state_e state,
  output ctrl_t  ctrl
);

  // Every field defaults to 0; each state only raises what it needs.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.ior_d    = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.ior_d     = 1'b1;
      end
      S_RTEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_RTWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BEQ: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit: Moore FSM, retired-instruction counter and
// sticky illegal-opcode flag. Control outputs come from mips_mc_decode.
// Optional feature macro: MIPS_MC_ADDI_EN enables the addi instruction.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       opcode,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemToReg,
  output logic             IRWrite,
  output logic             AluSrcA,
  output logic             RegWrite,
  output logic             RegDst,
  output logic [1:0]       PCSource,
  output logic [1:0]       AluSrcB,
  output logic [1:0]       AluOp,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count,
  output logic [3:0]       state_o
);

  state_e state_q;
  state_e state_d;
  logic   decode_bad;
  ctrl_t  ctrl;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; start overrides everything, stray encodings fall to IDLE.
  always_comb begin
    state_d    = S_IDLE;
    decode_bad = 1'b0;
    if (start) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:   state_d = S_FETCH;
        S_FETCH:  state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_RTYPE:     state_d = S_RTEXEC;
            OP_BEQ:       state_d = S_BEQ;
            OP_J:         state_d = S_JUMP;
`ifdef MIPS_MC_ADDI_EN
            OP_ADDI:      state_d = S_ADDIEX;
`endif
            default: begin
              state_d    = S_FETCH;
              decode_bad = 1'b1;
            end
          endcase
        end
        // Only lw and sw reach MEMADR, so bit 3 of the opcode picks the path.
        S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_d = S_MEMWB;
        S_RTEXEC: state_d = S_RTWB;
        S_MEMWB, S_MEMWR, S_RTWB, S_BEQ, S_JUMP: state_d = S_FETCH;
`ifdef MIPS_MC_ADDI_EN
        S_ADDIEX: state_d = S_ADDIWB;
        S_ADDIWB: state_d = S_FETCH;
`endif
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Retire counter: counts terminal-state exits to FETCH, wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if (!start && state_d == S_FETCH && is_terminal(state_q)) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Sticky illegal flag: set on a bad decode, cleared when leaving IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal <= 1'b0;
    end else if (!start) begin
      if (state_q == S_IDLE) illegal <= 1'b0;
      else if (decode_bad)   illegal <= 1'b1;
    end
  end

  mips_mc_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  assign PCWrite     = ctrl.pc_write;
  assign PCWriteCond = ctrl.pc_write_cond;
  assign IorD        = ctrl.ior_d;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign MemToReg    = ctrl.mem_to_reg;
  assign IRWrite     = ctrl.ir_write;
  assign AluSrcA     = ctrl.alu_src_a;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign PCSource    = ctrl.pc_source;
  assign AluSrcB     = ctrl.alu_src_b;
  assign AluOp       = ctrl.alu_op;
  assign state_o     = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Testbench for mips_mc_ctrl: instruction-path model plus directed vectors.
// Optional feature macro: MIPS_MC_ADDI_EN selects the addi expectations.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [5:0]       opcode;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg;
  logic             IRWrite, AluSrcA, RegWrite, RegDst;
  logic [1:0]       PCSource, AluSrcB, AluOp;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [3:0]       state_o;

  int n_total = 0;
  int n_bad   = 0;

  mips_mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg),
    .IRWrite(IRWrite), .AluSrcA(AluSrcA), .RegWrite(RegWrite),
    .RegDst(RegDst), .PCSource(PCSource), .AluSrcB(AluSrcB), .AluOp(AluOp),
    .illegal(illegal), .instr_count(instr_count), .state_o(state_o)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [15:0] dut_cw = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemToReg,
                        IRWrite, AluSrcA, RegWrite, RegDst, PCSource, AluSrcB, AluOp};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Control table written straight from the per-state output list.
  function automatic logic [15:0] exp_cw(input state_e s);
    logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd;
    logic [1:0] pcs, asb, aop;
    {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (s)
      S_FETCH:  begin mrd = 1; irw = 1; asb = 2'b01; pcw = 1; end
      S_DECODE: begin asb = 2'b11; end
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mrd = 1; iord = 1; end
      S_MEMWB:  begin rw = 1; m2r = 1; end
      S_MEMWR:  begin mwr = 1; iord = 1; end
      S_RTEXEC: begin asa = 1; aop = 2'b10; end
      S_RTWB:   begin rw = 1; rd = 1; end
      S_BEQ:    begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; end
`ifdef MIPS_MC_ADDI_EN
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: begin rw = 1; end
`endif
      default: ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, asb, aop};
  endfunction

  // Model: each decoded instruction becomes a queue of states still to visit;
  // an emptied queue means the instruction retires on the way back to FETCH.
  state_e           m_cur;
  state_e           path_q[$];
  logic [CNT_W-1:0] m_cnt;
  logic             m_ill;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cur = S_IDLE; path_q.delete(); m_cnt = '0; m_ill = 1'b0;
    end else if (start) begin
      m_cur = S_IDLE; path_q.delete();
    end else if (m_cur == S_IDLE) begin
      m_cur = S_FETCH; m_ill = 1'b0;
    end else if (m_cur == S_FETCH) begin
      m_cur = S_DECODE;
    end else if (m_cur == S_DECODE) begin
      path_q.delete();
      case (opcode)
        6'b100011: begin path_q.push_back(S_MEMADR); path_q.push_back(S_MEMRD); path_q.push_back(S_MEMWB); end
        6'b101011: begin path_q.push_back(S_MEMADR); path_q.push_back(S_MEMWR); end
        6'b000000: begin path_q.push_back(S_RTEXEC); path_q.push_back(S_RTWB); end
        6'b000100: path_q.push_back(S_BEQ);
        6'b000010: path_q.push_back(S_JUMP);
`ifdef MIPS_MC_ADDI_EN
        6'b001000: begin path_q.push_back(S_ADDIEX); path_q.push_back(S_ADDIWB); end
`endif
        default: ;
      endcase
      if (path_q.size() == 0) begin
        m_cur = S_FETCH; m_ill = 1'b1;
      end else begin
        m_cur = path_q.pop_front();
      end
    end else if (path_q.size() > 0) begin
      m_cur = path_q.pop_front();
    end else begin
      m_cur = S_FETCH; m_cnt = m_cnt + 1'b1;
    end
  end

  // Scoreboard compare on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_state", 32'(state_o), 32'(m_cur));
      chk("model_ctrl", 32'(dut_cw), 32'(exp_cw(m_cur)));
      chk("model_count", 32'(instr_count), 32'(m_cnt));
      chk("model_illegal", 32'(illegal), 32'(m_ill));
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [5:0] mix_ops [8];

  initial begin
    rst_n = 1'b0; start = 1'b1; opcode = 6'b100011;
    #12;
    chk("reset_state", 32'(state_o), 32'd0);
    chk("reset_ctrl", 32'(dut_cw), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_illegal", 32'(illegal), 32'd0);

    // lw from reset release
    start = 1'b0; rst_n = 1'b1;
    tick(); chk("lw_fetch", 32'(state_o), 32'(S_FETCH));
    tick(); chk("lw_decode", 32'(state_o), 32'(S_DECODE));
    chk("lw_m2r_decode", 32'(MemToReg), 32'd0);
    tick(); chk("lw_memadr", 32'(state_o), 32'(S_MEMADR));
    tick(); chk("lw_memrd", 32'(state_o), 32'(S_MEMRD));
    chk("lw_m2r_memrd", 32'(MemToReg), 32'd0);
    tick(); chk("lw_memwb", 32'(state_o), 32'(S_MEMWB));
    chk("lw_m2r_memwb", 32'(MemToReg), 32'd1);
    tick(); chk("lw_back", 32'(state_o), 32'(S_FETCH));
    chk("lw_count", 32'(instr_count), 32'd1);
    chk("lw_m2r_fetch", 32'(MemToReg), 32'd0);

    // beq
    opcode = 6'b000100;
    tick(); tick();
    chk("beq_state", 32'(state_o), 32'(S_BEQ));
    chk("beq_pcwc", 32'(PCWriteCond), 32'd1);
    chk("beq_pcsrc", 32'(PCSource), 32'b01);
    chk("beq_aluop", 32'(AluOp), 32'b01);
    tick(); chk("beq_back", 32'(state_o), 32'(S_FETCH));
    chk("beq_count", 32'(instr_count), 32'd2);

    // illegal opcode, then sw with the flag still held
    opcode = 6'b111111;
    tick(); tick();
    chk("ill_state", 32'(state_o), 32'(S_FETCH));
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_count", 32'(instr_count), 32'd2);
    opcode = 6'b101011;
    ticks(3); chk("sw_memwr", 32'(state_o), 32'(S_MEMWR));
    tick(); chk("sw_count", 32'(instr_count), 32'd3);
    chk("ill_held", 32'(illegal), 32'd1);
    start = 1'b1;
    tick(); chk("start_idle", 32'(state_o), 32'(S_IDLE));
    tick(); chk("ill_held_start", 32'(illegal), 32'd1);
    start = 1'b0;
    tick(); chk("ill_cleared", 32'(illegal), 32'd0);
    chk("restart_count", 32'(instr_count), 32'd3);

    // R-type aborted by start in RTEXEC
    opcode = 6'b000000;
    tick(); tick(); chk("rt_exec", 32'(state_o), 32'(S_RTEXEC));
    start = 1'b1;
    tick(); chk("rt_abort_state", 32'(state_o), 32'(S_IDLE));
    chk("rt_abort_rw", 32'(RegWrite), 32'd0);
    chk("rt_abort_count", 32'(instr_count), 32'd3);
    start = 1'b0;
    tick();

    // j until the 4-bit counter wraps
    opcode = 6'b000010;
    for (int i = 0; i < 12; i++) ticks(3);
    chk("j_count_max", 32'(instr_count), 32'd15);
    ticks(3);
    chk("j_count_wrap", 32'(instr_count), 32'd0);

    // addi
    opcode = 6'b001000;
    tick(); tick();
`ifdef MIPS_MC_ADDI_EN
    chk("addi_ex", 32'(state_o), 32'(S_ADDIEX));
    tick(); chk("addi_wb", 32'(state_o), 32'(S_ADDIWB));
    chk("addi_rw", 32'(RegWrite), 32'd1);
    tick(); chk("addi_count", 32'(instr_count), 32'd1);
`else
    chk("addi_illegal_state", 32'(state_o), 32'(S_FETCH));
    chk("addi_illegal", 32'(illegal), 32'd1);
    chk("addi_count", 32'(instr_count), 32'd0);
`endif

    // async reset in the middle of MEMWR
    opcode = 6'b101011;
    ticks(3); chk("rst_memwr", 32'(MemWrite), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_mw", 32'(MemWrite), 32'd0);
    chk("rst_async_cnt", 32'(instr_count), 32'd0);
    chk("rst_async_st", 32'(state_o), 32'd0);
    start = 1'b1;
    #10 rst_n = 1'b1;
    tick(); chk("rst_hold_idle", 32'(state_o), 32'(S_IDLE));
    start = 1'b0;
    tick(); chk("rst_first_fetch", 32'(state_o), 32'(S_FETCH));

    // mixed opcode sequence, checked by the model only
    mix_ops = '{6'b100011, 6'b000000, 6'b001000, 6'b000100,
                6'b101011, 6'b000111, 6'b000010, 6'b100011};
    for (int i = 0; i < 8; i++) begin
      opcode = mix_ops[i];
      ticks(5);
      if (i == 4) begin
        start = 1'b1; tick(); start = 1'b0;
      end
    end

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
